ccff_programmer: RTL and testbench
==================================

CCFF_PROGRAMMER -- requirements
Module: ccff_programmer

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, meaning the number of configuration flip-flops in the chain (legal range 1..65535).
REQ-002 SHALL have parameter DIV, default 1, meaning CK cycles per shifted bit (legal range 1..255).
REQ-003 SHALL have port CK, input, 1, the single clock.
REQ-004 SHALL have port RST, input, 1, synchronous active-low reset.
REQ-005 SHALL have port START, input, 1, a one-cycle request to begin programming.
REQ-006 SHALL have port ABORT, input, 1, which cancels programming.
REQ-007 SHALL have port DIN, input, 8, the bitstream byte, shifted LSB first.
REQ-008 SHALL have port DIN_VALID, input, 1, meaning DIN holds a valid byte.
REQ-009 SHALL have port DIN_READY, output, 1, meaning the block accepts DIN this cycle.
REQ-010 SHALL have port CCFF_HEAD, output, 1, the serial data driven into the chain head.
REQ-011 SHALL have port CCFF_SHIFT_EN, output, 1, the chain shift enable; the chain captures CCFF_HEAD on the CK edge where it is high.
REQ-012 SHALL have port CCFF_TAIL, input, 1, the serial data from the chain tail (readback).
REQ-013 SHALL have port BUSY, output, 1, high in every state except IDLE.
REQ-014 SHALL have port DONE, output, 1, a one-cycle completion pulse.
REQ-015 SHALL have port TAIL_PARITY, output, 1, the XOR of all tail bits captured during the current or last run.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SHIFT, WAIT and FINISH.
REQ-017 SHALL move from IDLE to LOAD on START=1, clear TAIL_PARITY and clear the bit counter (width clog2(CHAIN_LEN+1)).
REQ-018 SHALL ignore START in every state except IDLE.
REQ-019 SHALL drive DIN_READY=1 only in LOAD; a byte is accepted on an edge where DIN_VALID=1 and DIN_READY=1, the byte is latched, and the next state is SHIFT.
REQ-020 SHALL remain in LOAD with no timeout while DIN_VALID=0.
REQ-021 SHALL, in SHIFT, register CCFF_HEAD = the current byte bit (bit index 0..7) and CCFF_SHIFT_EN=1 for exactly one cycle, then increment the bit counter.
REQ-022 SHALL, after each SHIFT cycle, spend DIV-1 cycles in WAIT with CCFF_SHIFT_EN=0 and CCFF_HEAD held; when DIV=1, WAIT is skipped.
REQ-023 SHALL make the bit pitch exactly DIV cycles, giving consecutive CCFF_SHIFT_EN pulses DIV cycles apart within a byte.
REQ-024 SHALL, after 8 bits of a byte, return to LOAD, which adds at least 1 cycle of byte gap.
REQ-025 SHALL, when the bit counter reaches CHAIN_LEN, go to FINISH immediately, even mid-byte; the unused upper bits of the final byte are discarded.
REQ-026 SHALL, in FINISH, assert DONE=1 for one cycle and then return to IDLE; BUSY=0 in the cycle after FINISH.
REQ-027 SHALL update TAIL_PARITY ^= CCFF_TAIL on every edge where CCFF_SHIFT_EN=1, and hold it otherwise.
REQ-028 SHALL give ABORT=1 priority over all other inputs: from any non-IDLE state the next state is IDLE, CCFF_SHIFT_EN=0, no DONE pulse, and TAIL_PARITY holds.
REQ-029 SHALL, when START and ABORT are both 1 in IDLE, remain in IDLE.
REQ-030 SHALL keep the total number of CCFF_SHIFT_EN pulses per completed run equal to exactly CHAIN_LEN.
REQ-031 SHALL produce every output from a flip-flop, with no combinational path from input to output.

Reset
REQ-032 SHALL, on a CK edge with RST=0, set the state to IDLE and drive DIN_READY=0, CCFF_HEAD=0, CCFF_SHIFT_EN=0, BUSY=0, DONE=0 and TAIL_PARITY=0, with the counters cleared.
REQ-033 SHALL treat reset asserted mid-run exactly as an abort that also clears TAIL_PARITY; the next START after reset release begins a full new run.

Verification
REQ-034 SHALL be verified with CHAIN_LEN=12, DIV=1: START, DIN=0xA5 then 0x0F -> CCFF_HEAD at the shift pulses is 1,0,1,0,0,1,0,1,1,1,1,1, with 12 pulses, then a DONE pulse and DIN_READY low afterwards.
REQ-035 SHALL be verified with CHAIN_LEN=8, DIV=3, DIN=0xFF -> 8 CCFF_SHIFT_EN pulses spaced exactly 3 cycles apart and DONE 1 cycle after the last pulse's FINISH entry.
REQ-036 SHALL be verified with CHAIN_LEN=16 and DIN_VALID held low 20 cycles in LOAD -> no shift pulses and BUSY=1; then both bytes are accepted -> 16 pulses.
REQ-037 SHALL be verified with CHAIN_LEN=16, CCFF_TAIL tied 1, and a full run -> TAIL_PARITY=0 (16 ones); with CHAIN_LEN=9 -> TAIL_PARITY=1.
REQ-038 SHALL be verified with ABORT pulsed after 5 shifts -> IDLE next cycle, no further pulses, DONE never asserted; a following START gives a full CHAIN_LEN run.
REQ-039 SHALL be verified with RST=0 during SHIFT -> all outputs at their reset values on the next edge; START during a run -> ignored, pulse count unchanged.

Source files
------------

// File: rtl/ccff_programmer.sv
`default_nettype none
// ============================================================================
// Module   : ccff_programmer
// Purpose  : Serialises a byte stream (LSB first) into a configuration
//            flip-flop chain, one bit every DIV clock cycles, stopping after
//            exactly CHAIN_LEN bits. Tail bits read back from the chain are
//            folded into a running parity.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CK            in   clock
//   RST           in   synchronous reset, active low
//   START         in   one-cycle request to begin programming (IDLE only)
//   ABORT         in   cancels a run in progress (highest priority)
//   DIN[7:0]      in   bitstream byte, shifted LSB first
//   DIN_VALID     in   DIN holds a valid byte
//   DIN_READY     out  byte accepted on this cycle's edge if DIN_VALID=1
//   CCFF_HEAD     out  serial data into the chain head
//   CCFF_SHIFT_EN out  chain captures CCFF_HEAD on edges where this is high
//   CCFF_TAIL     in   serial data from the chain tail
//   BUSY          out  high whenever a run is in progress
//   DONE          out  one-cycle completion pulse
//   TAIL_PARITY   out  XOR of tail bits captured in the current/last run
// ============================================================================
module ccff_programmer #(
  parameter int CHAIN_LEN = 64,
  parameter int DIV       = 1
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       CCFF_HEAD,
  output logic       CCFF_SHIFT_EN,
  input  logic       CCFF_TAIL,
  output logic       BUSY,
  output logic       DONE,
  output logic       TAIL_PARITY
);

  localparam int                  c_cnt_w     = $clog2(CHAIN_LEN + 1);
  localparam logic [c_cnt_w-1:0]  c_last_cnt  = c_cnt_w'(CHAIN_LEN - 1);
  localparam logic [7:0]          c_wait_load = 8'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_bit_cnt;   // bits shifted so far in this run
  logic [7:0]         r_byte;      // byte being serialised
  logic [2:0]         r_bit_idx;   // index of the bit currently on CCFF_HEAD
  logic [7:0]         r_wait_cnt;  // remaining WAIT cycles in this bit slot
  logic [2:0]         w_next_idx;

  assign w_next_idx = r_bit_idx + 3'd1;

  // All outputs are assigned for the state being entered, so they are pure
  // flops and line up cycle-for-cycle with the state they describe.
  always_ff @(posedge CK) begin
    if (!RST) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_byte        <= '0;
      r_bit_idx     <= '0;
      r_wait_cnt    <= '0;
      DIN_READY     <= 1'b0;
      CCFF_HEAD     <= 1'b0;
      CCFF_SHIFT_EN <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      TAIL_PARITY   <= 1'b0;
    end else if (ABORT && (r_state != ST_IDLE)) begin
      // Abort suppresses the parity update even on a shift cycle.
      r_state       <= ST_IDLE;
      DIN_READY     <= 1'b0;
      CCFF_SHIFT_EN <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START && !ABORT) begin
            r_state     <= ST_LOAD;
            r_bit_cnt   <= '0;
            TAIL_PARITY <= 1'b0;
            DIN_READY   <= 1'b1;
            BUSY        <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (DIN_VALID) begin
            r_state       <= ST_SHIFT;
            r_byte        <= DIN;
            r_bit_idx     <= 3'd0;
            CCFF_HEAD     <= DIN[0];
            CCFF_SHIFT_EN <= 1'b1;
            DIN_READY     <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // The chain captures on this edge; fold in its tail bit.
          TAIL_PARITY   <= TAIL_PARITY ^ CCFF_TAIL;
          r_bit_cnt     <= r_bit_cnt + 1'b1;
          CCFF_SHIFT_EN <= 1'b0;
          if (r_bit_cnt == c_last_cnt) begin
            r_state <= ST_FINISH;
            DONE    <= 1'b1;
          end else if (DIV > 1) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= c_wait_load;
          end else if (r_bit_idx == 3'd7) begin
            r_state   <= ST_LOAD;
            DIN_READY <= 1'b1;
          end else begin
            r_bit_idx     <= w_next_idx;
            CCFF_HEAD     <= r_byte[w_next_idx];
            CCFF_SHIFT_EN <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (r_wait_cnt == 8'd1) begin
            if (r_bit_idx == 3'd7) begin
              r_state   <= ST_LOAD;
              DIN_READY <= 1'b1;
            end else begin
              r_state       <= ST_SHIFT;
              r_bit_idx     <= w_next_idx;
              CCFF_HEAD     <= r_byte[w_next_idx];
              CCFF_SHIFT_EN <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
        end

        default: begin
          r_state       <= ST_IDLE;
          DIN_READY     <= 1'b0;
          CCFF_SHIFT_EN <= 1'b0;
          BUSY          <= 1'b0;
          DONE          <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccff_programmer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ccff_programmer
// Purpose  : Four ccff_programmer instances with different CHAIN_LEN/DIV share
//            one stimulus stream; each is compared every cycle against a
//            schedule-based model (bit k of a byte lands k*DIV cycles after
//            acceptance, next byte request 8*DIV cycles after acceptance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_programmer;

  logic       CK = 1'b0;
  logic       RST, START, ABORT, DIN_VALID, TAIL;
  logic [7:0] DIN;
  logic [3:0] rdy, head, sh, busy, done, par;

  always #5 CK = ~CK;

  ccff_programmer #(.CHAIN_LEN(12), .DIV(1)) u_a (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(rdy[0]), .CCFF_HEAD(head[0]), .CCFF_SHIFT_EN(sh[0]), .CCFF_TAIL(TAIL),
    .BUSY(busy[0]), .DONE(done[0]), .TAIL_PARITY(par[0]));
  ccff_programmer #(.CHAIN_LEN(8), .DIV(3)) u_b (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(rdy[1]), .CCFF_HEAD(head[1]), .CCFF_SHIFT_EN(sh[1]), .CCFF_TAIL(TAIL),
    .BUSY(busy[1]), .DONE(done[1]), .TAIL_PARITY(par[1]));
  ccff_programmer #(.CHAIN_LEN(16), .DIV(1)) u_c (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(rdy[2]), .CCFF_HEAD(head[2]), .CCFF_SHIFT_EN(sh[2]), .CCFF_TAIL(TAIL),
    .BUSY(busy[2]), .DONE(done[2]), .TAIL_PARITY(par[2]));
  ccff_programmer #(.CHAIN_LEN(9), .DIV(2)) u_d (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(rdy[3]), .CCFF_HEAD(head[3]), .CCFF_SHIFT_EN(sh[3]), .CCFF_TAIL(TAIL),
    .BUSY(busy[3]), .DONE(done[3]), .TAIL_PARITY(par[3]));

  function automatic int cl_of(int k);
    case (k)
      0: return 12;
      1: return 8;
      2: return 16;
      default: return 9;
    endcase
  endfunction

  function automatic int dv_of(int k);
    case (k)
      1: return 3;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  // Model modes
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_BYTE = 2;
  localparam int M_DONE = 3;

  int         m_mode[4];
  int         m_t[4];       // cycles since the current byte was accepted
  int         m_pulses[4];  // bits delivered this run
  logic [7:0] m_byte[4];
  logic       m_par[4];
  logic       m_head[4];
  logic       m_hchk[4];    // head known to be zero since reset

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int obs_p[4];
  int obs_d[4];
  logic hq_a[$];
  int   b_pc[$];
  int   b_dc[$];
  bit   rnd = 1'b0;

  task automatic chk(string nm, int k, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic bit exp_sh(int k);
    return (m_mode[k] == M_BYTE) && ((m_t[k] % dv_of(k)) == 0);
  endfunction

  task automatic model_step(int k);
    int dv;
    dv = dv_of(k);
    if (!RST) begin
      m_mode[k] = M_IDLE; m_par[k] = 1'b0; m_pulses[k] = 0;
      m_head[k] = 1'b0;   m_hchk[k] = 1'b1;
    end else if (ABORT && m_mode[k] != M_IDLE) begin
      m_mode[k] = M_IDLE;
    end else begin
      case (m_mode[k])
        M_IDLE: if (START && !ABORT) begin
          m_mode[k] = M_LOAD; m_par[k] = 1'b0; m_pulses[k] = 0;
        end
        M_LOAD: if (DIN_VALID) begin
          m_mode[k] = M_BYTE; m_t[k] = 0; m_byte[k] = DIN;
          m_head[k] = DIN[0]; m_hchk[k] = 1'b0;
        end
        M_BYTE: begin
          if ((m_t[k] % dv) == 0) begin
            m_par[k] = m_par[k] ^ TAIL;
            m_pulses[k]++;
          end
          if (m_pulses[k] == cl_of(k) && (m_t[k] % dv) == 0) begin
            m_mode[k] = M_DONE;
          end else begin
            m_t[k]++;
            if (m_t[k] == 8 * dv) m_mode[k] = M_LOAD;
            else if ((m_t[k] % dv) == 0) m_head[k] = m_byte[k][m_t[k] / dv];
          end
        end
        default: m_mode[k] = M_IDLE;
      endcase
    end
  endtask

  always @(posedge CK) begin
    for (int k = 0; k < 4; k++) model_step(k);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      chk("busy",   k, int'(busy[k]), int'(m_mode[k] != M_IDLE));
      chk("ready",  k, int'(rdy[k]),  int'(m_mode[k] == M_LOAD));
      chk("shift",  k, int'(sh[k]),   int'(exp_sh(k)));
      chk("done",   k, int'(done[k]), int'(m_mode[k] == M_DONE));
      chk("parity", k, int'(par[k]),  int'(m_par[k]));
      if (m_mode[k] == M_BYTE || m_hchk[k])
        chk("head", k, int'(head[k]), int'(m_head[k]));
      if (sh[k])   obs_p[k]++;
      if (done[k]) obs_d[k]++;
    end
    if (sh[0])   hq_a.push_back(head[0]);
    if (sh[1])   b_pc.push_back(cyc);
    if (done[1]) b_dc.push_back(cyc);
  end

  task automatic step();
    @(negedge CK);
    if (rnd) begin
      DIN  = 8'($urandom);
      TAIL = 1'($urandom);
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) begin obs_p[k] = 0; obs_d[k] = 0; end
    hq_a.delete(); b_pc.delete(); b_dc.delete();
  endtask

  task automatic pulse_start();
    START = 1'b1; step(); START = 1'b0;
  endtask

  task automatic wait_idle(string nm, int limit);
    int c = 0;
    step();
    while (busy != 4'b0000 && c < limit) begin step(); c++; end
    chk(nm, 0, int'(busy == 4'b0000), 1);
  endtask

  task automatic wait_pulses(string nm, int k, int n, int limit);
    int c = 0;
    while (obs_p[k] < n && c < limit) begin step(); c++; end
    chk(nm, k, int'(obs_p[k] >= n), 1);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_busy"},  0, int'(busy), 0);
    chk({nm, "_ready"}, 0, int'(rdy),  0);
    chk({nm, "_shift"}, 0, int'(sh),   0);
    chk({nm, "_done"},  0, int'(done), 0);
    chk({nm, "_par"},   0, int'(par),  0);
    chk({nm, "_head"},  0, int'(head), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_a [12];
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    RST = 1'b0; START = 1'b0; ABORT = 1'b0; DIN_VALID = 1'b0; TAIL = 1'b0; DIN = 8'h00;
    clear_obs();
    repeat (3) step();
    chk_all_zero("reset");
    RST = 1'b1;
    step();

    // Byte stream A5, 0F with a 20-cycle stall in LOAD; tail tied high.
    clear_obs();
    TAIL = 1'b1;
    pulse_start();
    repeat (20) step();
    chk("stall_pulses", 2, obs_p[2], 0);
    chk("stall_busy",   2, int'(busy[2]), 1);
    DIN = 8'hA5; DIN_VALID = 1'b1;
    step();
    DIN = 8'h0F;
    wait_idle("run1_timeout", 300);
    DIN_VALID = 1'b0;
    chk("a_pulses", 0, obs_p[0], 12);
    chk("a_dones",  0, obs_d[0], 1);
    chk("a_heads_n", 0, hq_a.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < hq_a.size()) chk("a_head_seq", 0, int'(hq_a[i]), int'(exp_a[i]));
    chk("a_ready_after", 0, int'(rdy[0]), 0);
    chk("b_pulses", 1, b_pc.size(), 8);
    for (int i = 1; i < b_pc.size(); i++) chk("b_spacing", 1, b_pc[i] - b_pc[i-1], 3);
    chk("b_dones", 1, b_dc.size(), 1);
    if (b_dc.size() == 1 && b_pc.size() == 8) chk("b_done_cycle", 1, b_dc[0], b_pc[7] + 1);
    chk("c_pulses", 2, obs_p[2], 16);
    chk("c_parity", 2, int'(par[2]), 0);
    chk("d_pulses", 3, obs_p[3], 9);
    chk("d_parity", 3, int'(par[3]), 1);

    // Abort after five shifts, then a complete run with a stray START.
    rnd = 1'b1;
    clear_obs();
    DIN_VALID = 1'b1;
    pulse_start();
    wait_pulses("abort_wait", 0, 5, 100);
    ABORT = 1'b1; step(); ABORT = 1'b0;
    chk("abort_idle", 0, int'(busy), 0);
    repeat (30) step();
    chk("abort_pulses", 0, obs_p[0], 5);
    chk("abort_dones",  0, obs_d[0] + obs_d[1] + obs_d[2] + obs_d[3], 0);
    clear_obs();
    pulse_start();
    wait_pulses("restart_wait", 0, 2, 100);
    pulse_start();
    wait_idle("run2_timeout", 400);
    chk("run2_a_pulses", 0, obs_p[0], 12);
    chk("run2_a_dones",  0, obs_d[0], 1);
    chk("run2_b_pulses", 1, obs_p[1], 8);
    chk("run2_c_pulses", 2, obs_p[2], 16);
    chk("run2_d_pulses", 3, obs_p[3], 9);

    // Reset in the middle of shifting.
    clear_obs();
    pulse_start();
    wait_pulses("rst_wait", 0, 3, 100);
    RST = 1'b0; step(); RST = 1'b1;
    chk_all_zero("midrst");
    repeat (10) step();
    chk("midrst_pulses", 0, obs_p[0], 3);
    clear_obs();
    pulse_start();
    wait_idle("run3_timeout", 400);
    chk("run3_a_pulses", 0, obs_p[0], 12);
    chk("run3_c_pulses", 2, obs_p[2], 16);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      START     = (($urandom % 16) == 0);
      ABORT     = (($urandom % 80) == 0);
      DIN_VALID = (($urandom % 3) != 0);
      RST       = (($urandom % 600) != 0);
      step();
    end
    START = 1'b0; ABORT = 1'b0; RST = 1'b1; DIN_VALID = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
